// File: rtl/word_splitter.sv
// word_splitter: byte-serial receiver that packs four bytes into a word and splits it into fields.
//   clk, rst           clock, synchronous active-high reset
//   in_byte/in_valid   byte stream input; in_ready back-pressures only the 4th byte
//   out_valid/out_ready one-deep output register handshake
//   out_word, a..e     assembled word {a,b,c,d,e} and its field slices
//   timeout_err        one-cycle pulse when a stalled partial word is discarded
//   word_count         output handshakes, modulo 256
module word_splitter #(
  parameter bit MSB_FIRST = 1'b1,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [7:0]  a,
  output logic [7:0]  b,
  output logic [7:0]  c,
  output logic [3:0]  d,
  output logic [3:0]  e,
  output logic        timeout_err,
  output logic [7:0]  word_count
);
  localparam int IW = $clog2(TIMEOUT);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);
  typedef enum logic [1:0] {COLLECT0, COLLECT1, COLLECT2, COLLECT3} state_t;
  state_t state, state_n;
  logic [23:0] asm_q, asm_n;
  logic [IW-1:0] idle, idle_n;
  logic accept, last, load, hs, fire;
  logic [31:0] word;
  assign last = state == COLLECT3;
  // The timeout fires on the edge that would make the idle count reach TIMEOUT;
  // input is refused that cycle so a late byte cannot join the discarded word.
  assign fire = state != COLLECT0 && idle == IDLE_MAX;
  assign in_ready = !fire && (!last || !out_valid || out_ready);
  assign accept = in_valid && in_ready;
  assign load = accept && last;
  assign hs = out_valid && out_ready;
  assign word = MSB_FIRST ? {asm_q, in_byte} : {in_byte, asm_q};
  assign {a, b, c, d, e} = out_word;
  always_comb begin
    state_n = fire ? COLLECT0 : accept ? state_t'(state + 2'd1) : state;
    asm_n = fire ? '0 : !accept ? asm_q : MSB_FIRST ? {asm_q[15:0], in_byte} : {in_byte, asm_q[23:8]};
    idle_n = (fire || accept || state == COLLECT0) ? '0 : idle + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT0;
      asm_q <= '0;
      idle <= '0;
      out_valid <= 1'b0;
      out_word <= '0;
      timeout_err <= 1'b0;
      word_count <= '0;
    end else begin
      state <= state_n;
      asm_q <= asm_n;
      idle <= idle_n;
      out_valid <= load || (out_valid && !hs);
      if (load) out_word <= word;
      timeout_err <= fire;
      if (hs) word_count <= word_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_word_splitter.sv
// tb_word_splitter: scoreboard bench for word_splitter in both byte orders.
module tb_word_splitter;
  logic clk = 0, rst = 1;
  logic [7:0] in_byte = 0, in_byte2 = 0;
  logic in_valid = 0, in_valid2 = 0, out_ready = 0, out_ready2 = 1;
  logic in_ready, out_valid, timeout_err, in_ready2, out_valid2, timeout_err2;
  logic [31:0] out_word, out_word2;
  logic [7:0] a, b, c, a2, b2, c2, word_count, word_count2;
  logic [3:0] d, e, d2, e2;
  int checks = 0, errors = 0, drops = 0;
  logic last_ready;
  logic [31:0] q1[$], q2[$];

  always #5 clk = ~clk;

  word_splitter #(.MSB_FIRST(1'b1), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .a(a), .b(b), .c(c), .d(d), .e(e), .timeout_err(timeout_err), .word_count(word_count));

  word_splitter #(.MSB_FIRST(1'b0), .TIMEOUT(16)) dut2 (
    .clk(clk), .rst(rst), .in_byte(in_byte2), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_word(out_word2),
    .a(a2), .b(b2), .c(c2), .d(d2), .e(e2), .timeout_err(timeout_err2), .word_count(word_count2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] v);
    int g = 0;
    in_byte = v;
    in_valid = 1;
    @(negedge clk);
    last_ready = in_ready;
    if (!in_ready) drops++;
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic send2(input logic [7:0] v);
    int g = 0;
    in_byte2 = v;
    in_valid2 = 1;
    @(negedge clk);
    while (!in_ready2 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) chk("send2_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid2 = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q1.size() == 0) chk("unexpected_word", out_word, 32'hx);
      else begin
        logic [31:0] x;
        x = q1.pop_front();
        chk("out_word", out_word, x);
        chk("fields", {a, b, c, d, e}, x);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid2 && out_ready2) begin
      if (q2.size() == 0) chk("unexpected_word2", out_word2, 32'hx);
      else begin
        logic [31:0] x;
        x = q2.pop_front();
        chk("out_word2", out_word2, x);
        chk("fields2", {a2, b2, c2, d2, e2}, x);
      end
    end
  end

  initial begin
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_word", out_word, 0);
    chk("rst_word_count", 32'(word_count), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    chk("rst_in_ready", 32'(in_ready), 1);

    out_ready = 1;
    q1.push_back(32'h10021279);
    send(8'h10); send(8'h02); send(8'h12); send(8'h79);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_a", 32'(a), 32'h10);
    chk("t1_b", 32'(b), 32'h02);
    chk("t1_c", 32'(c), 32'h12);
    chk("t1_d", 32'(d), 7);
    chk("t1_e", 32'(e), 9);
    @(posedge clk); #1;
    chk("t1_count", 32'(word_count), 1);
    chk("t1_drained", 32'(out_valid), 0);

    q2.push_back(32'h10021279);
    send2(8'h79); send2(8'h12); send2(8'h02); send2(8'h10);
    chk("t2_word", out_word2, 32'h10021279);
    @(posedge clk); #1;

    do_reset();
    out_ready = 0;
    q1.push_back(32'h14131047);
    q1.push_back(32'h14131047);
    send(8'h14); send(8'h13); send(8'h10); send(8'h47);
    chk("t3_held", 32'(out_valid), 1);
    send(8'h14); chk("t3_rdy1", 32'(last_ready), 1);
    send(8'h13); chk("t3_rdy2", 32'(last_ready), 1);
    send(8'h10); chk("t3_rdy3", 32'(last_ready), 1);
    in_byte = 8'h47;
    in_valid = 1;
    repeat (3) begin
      @(negedge clk);
      chk("t3_backpressure", 32'(in_ready), 0);
    end
    @(posedge clk);
    #1 out_ready = 1;
    send(8'h47);
    chk("t3_replace_valid", 32'(out_valid), 1);
    chk("t3_count1", 32'(word_count), 1);
    @(posedge clk); #1;
    chk("t3_count2", 32'(word_count), 2);
    chk("t3_drained", 32'(out_valid), 0);

    do_reset();
    send(8'h01); send(8'h02);
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (i == 15) chk("t4_fire_noready", 32'(in_ready), 0);
      if (i == 15) chk("t4_no_early_err", 32'(timeout_err), 0);
      if (i == 16) chk("t4_err_pulse", 32'(timeout_err), 1);
    end
    @(posedge clk); #1;
    chk("t4_err_one_cycle", 32'(timeout_err), 0);
    q1.push_back(32'hAABBCCDD);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    chk("t4_word", out_word, 32'hAABBCCDD);
    @(posedge clk); #1;

    do_reset();
    send(8'h55); send(8'h66); send(8'h77);
    do_reset();
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_word", out_word, 0);
    chk("t5_count", 32'(word_count), 0);
    chk("t5_err", 32'(timeout_err), 0);
    q1.push_back(32'h01020345);
    send(8'h01); send(8'h02); send(8'h03); send(8'h45);
    chk("t5_next", out_word, 32'h01020345);
    @(posedge clk); #1;

    do_reset();
    drops = 0;
    for (int j = 0; j < 256; j++) begin
      logic [7:0] k;
      k = 8'(4 * j);
      q1.push_back({k, k + 8'd1, k + 8'd2, k + 8'd3});
    end
    for (int i = 0; i < 1024; i++) send(8'(i));
    @(posedge clk); #1;
    chk("t6_no_drops", 32'(drops), 0);
    chk("t6_wrap", 32'(word_count), 0);
    repeat (3) @(posedge clk);
    chk("q1_empty", 32'(q1.size()), 0);
    chk("q2_empty", 32'(q2.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
